// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// FSM encodings and the bit-counter width derivation live here.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must be able to hold WIDTH itself, since it steps once past the last bit.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result handshake bundle for serial_adder_ctrl.
// Optional macro SERIAL_ADDER_SUB_EN adds the sub (subtract) request bit.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a_in, b_in, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a_in, b_in, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a_in, b_in, cin, input busy, done, sum, cout);
  modport slave  (input start, a_in, b_in, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// The team's FULL_ADDER cell: one-bit sum and carry of three inputs.
// Port order is carry out, sum out, then the three addend bits.
module serial_adder_ctrl_fa (
  output logic co,
  output logic s,
  input  logic a,
  input  logic b,
  input  logic c
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a subtract request (A - B via ~B and carry-in 1).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CNT_W = calc_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             shift;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             fa_co;
  logic             fa_s;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = bus.sub ? ~bus.b_in : bus.b_in;
  assign carry_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load     = bus.b_in;
  assign carry_load = bus.cin;
`endif

  serial_adder_ctrl_fa u_fa (
    .co (fa_co),
    .s  (fa_s),
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry)
  );

  // Result so far with this cycle's sum bit entering at the top.
  assign res_nxt = {fa_s, res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    load      = 1'b0;
    shift     = 1'b0;
    last      = 1'b0;
    case (state)
      RUN: begin
        shift = 1'b1;
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        // IDLE and any unused encoding behave identically.
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (load) begin
      a_sh  <= bus.a_in;
      b_sh  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (shift) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt[WIDTH-1:1];
      carry  <= fa_co;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        sum_q  <= res_nxt;
        cout_q <= fa_co;
      end
    end
  end

  assign bus.busy = (state == RUN) || (state == DONE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) with a result scoreboard.
// Subtract scenarios run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   done_cnt;
  logic [W:0] exp_q[$];

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s);
    bus.a_in = a;
    bus.b_in = b;
    bus.cin  = c;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub  = s;
`endif
  endtask

  // Drive one START pulse; returns at the negedge following the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s);
    @(negedge clk);
    drive(a, b, c, s);
    bus.start = 1'b1;
    exp_q.push_back(model(a, b, c, s));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at the negedge after the accepting edge (edge 0 counted as 1).
  task automatic wait_done(output int edges, output bit seen, output int busy_cyc);
    edges = 1;
    seen = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all zero",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input bit check_timing);
    int edges;
    bit seen;
    int bc;
    logic [W:0] e;
    launch(a, b, c, s);
    wait_done(edges, seen, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_timeout: no done within bound, want done", name);
    end else if ({bus.cout, bus.sum} !== e) begin
      n_bad++;
      $display("FAIL %s_result: got cout=%b sum=%h, want cout=%b sum=%h",
               name, bus.cout, bus.sum, e[W], e[W-1:0]);
    end
    if (check_timing) begin
      n_cmp++;
      if (edges != W + 1) begin
        n_bad++;
        $display("FAIL %s_latency: got %0d edges, want %0d", name, edges, W + 1);
      end
      n_cmp++;
      if (bc != W + 1) begin
        n_bad++;
        $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bc, W + 1);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s_return_idle: got done=%b busy=%b, want 0 0", name, bus.done, bus.busy);
    end
  endtask

  task automatic test_start_held();
    int edges;
    bit seen;
    int bc;
    logic [W:0] e;
    @(negedge clk);
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    bus.start = 1'b1;
    exp_q.push_back(model(8'h00, 8'h00, 1'b0, 1'b0));
    exp_q.push_back(model(8'h00, 8'h00, 1'b0, 1'b0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL held_relaunch%0d: got busy=%b, want 1", k, bus.busy);
      end
      wait_done(edges, seen, bc);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || {bus.cout, bus.sum} !== e) begin
        n_bad++;
        $display("FAIL held_result%0d: got seen=%b cout=%b sum=%h, want cout=%b sum=%h",
                 k, seen, bus.cout, bus.sum, e[W], e[W-1:0]);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL held_idle_gap%0d: got busy=%b, want 0", k, bus.busy);
      end
    end
  endtask

  task automatic test_busy_reject();
    int edges;
    bit seen;
    int bc;
    int d0;
    logic [W:0] e;
    d0 = done_cnt;
    launch(8'h01, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    drive(8'h80, 8'h80, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(edges, seen, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || {bus.cout, bus.sum} !== e) begin
      n_bad++;
      $display("FAIL busy_reject_result: got seen=%b cout=%b sum=%h, want cout=%b sum=%h",
               seen, bus.cout, bus.sum, e[W], e[W-1:0]);
    end
    repeat (15) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL busy_reject_done_count: got %0d pulses, want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_op();
    int d0;
    logic [W:0] e;
    d0 = done_cnt;
    launch(8'h55, 8'hAA, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_op: got busy=%b done=%b cout=%b sum=%h, want all zero (dropped %h)",
               bus.busy, bus.done, bus.cout, bus.sum, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0) begin
      n_bad++;
      $display("FAIL reset_mid_op_no_done: got %0d pulses, want 0", done_cnt - d0);
    end
    test_op("after_reset", 8'h55, 8'hAA, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    test_op("sub_no_borrow", 8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    test_op("sub_borrow", 8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
    test_op("sub_off_add", 8'h01, 8'h02, 1'b1, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    test_reset();
    test_op("basic_add", 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1);
    test_op("carry_ripple", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    test_op("carry_in", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    test_start_held();
    test_busy_reject();
    test_reset_mid_op();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that time-shares a single 1-bit full-adder cell to add two WIDTH-bit operands, LSB first, one bit per clock.
- Owns operand shift registers, the carry flip-flop, the bit counter and a start/done handshake.
- Sits between a requesting datapath and the team's FULL_ADDER cell, trading latency for area.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  one clock; reset is asynchronous and active-low
START  in  1  request pulse/level; sampled only in IDLE
A_IN  in  WIDTH  operand A, captured on accepted START
B_IN  in  WIDTH  operand B, captured on accepted START
CIN  in  1  carry-in, captured on accepted START
BUSY  out  1  high in RUN and DONE states
DONE  out  1  one-cycle pulse when SUM/COUT valid
SUM  out  WIDTH  result, held until next accepted START
COUT  out  1  final carry-out, held with SUM

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0, counter=0, carry FF=0, operand registers=0.
- FSM states:
  - IDLE: BUSY=0. On START=1 at a clock edge:
    - capture A_IN and B_IN into the shift registers;
    - load carry FF with CIN;
    - clear the counter;
    - go to RUN.
  - RUN: BUSY=1. Each clock:
    - the FA cell receives A_sh[0], B_sh[0] and carry;
    - its sum bit shifts into the MSB of the result register, which shifts right;
    - A_sh and B_sh shift right;
    - carry FF takes the FA carry-out;
    - counter increments.
    - When the counter reaches WIDTH-1 on an edge, that edge performs the last bit and the FSM moves to DONE.
  - DONE: BUSY=1, DONE=1 for exactly one cycle.
    - SUM = result register; COUT = carry FF.
    - Next edge goes to IDLE unconditionally.
- Latency: START accepted at edge 0 → DONE high in the cycle after edge WIDTH (DONE rises WIDTH+1 edges after acceptance). Throughput is one add per WIDTH+2 cycles.
- SUM/COUT are registered outputs. They change only on entry to DONE and hold through IDLE until the next result is produced. They are not cleared on a new START.
- START handling:
  - START while BUSY (RUN or DONE) is ignored, not queued.
  - START held high continuously launches a new add on the first IDLE edge.
- A_IN/B_IN/CIN changes after capture have no effect on the operation in flight.
- Arithmetic: {COUT,SUM} = A + B + CIN, modulo 2^(WIDTH+1); no saturation.
- RST_N asserted mid-RUN aborts immediately to the reset values. DONE is never issued for the aborted operation.
- Unreachable FSM encodings decode to IDLE.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), captured with the operands.
  - When SUB=1, the B register loads ~B_IN and the carry FF loads 1 (CIN ignored), so SUM = A - B mod 2^WIDTH.
  - COUT=1 means no borrow (A >= B unsigned).
  - SUB=0 behaves as the base adder.
- Undefined: no SUB port; add-only behaviour as above.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum/localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the CNT_W derivation function.
- One sub-module: the existing FULL_ADDER cell, instantiated once. Port order: carry out, sum out, A, B, C.
- FSM, counter and shift registers stay in serial_adder_ctrl.

Test Plan (WIDTH=8):
- Basic add: A=0x3C, B=0x0F, CIN=0, START pulse → DONE exactly 9 edges later; SUM=0x4B, COUT=0; BUSY high for 9 cycles.
- Carry ripple: A=0xFF, B=0x01, CIN=0 → SUM=0x00, COUT=1.
- Carry-in path: A=0xFF, B=0xFF, CIN=1 → SUM=0xFF, COUT=1. Then START held high for two consecutive ops with A=0x00, B=0x00, CIN=0 → SUM=0x00, COUT=0; second op starts on the first IDLE edge.
- Busy reject: START with A=0x01, B=0x01; re-pulse START with A=0x80, B=0x80 at cycle 4 → single DONE with SUM=0x02, COUT=0; no second DONE.
- Reset mid-op: START A=0x55, B=0xAA; drive RST_N low at cycle 5 → BUSY=0, SUM=0x00, COUT=0 immediately, no DONE. New op A=0x55, B=0xAA → SUM=0xFF, COUT=0.
- With SERIAL_ADDER_SUB_EN: SUB=1, A=0x10, B=0x01 → SUM=0x0F, COUT=1. SUB=1, A=0x01, B=0x02 → SUM=0xFF, COUT=0.
